// File: rtl/spectrum_pkg.sv
// Shared defaults and state encoding for the spectrum band-level pipeline.
package spectrum_pkg;

  localparam int unsigned DefFftLen     = 256;
  localparam int unsigned DefNumBands   = 16;
  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefLevelW     = 8;
  localparam int unsigned DefLevelShift = 11;
  localparam int unsigned DefDecay      = 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StSkip,
    StCommit
  } band_state_e;

endpackage

// File: rtl/cplx_mag_l1.sv
// Registered L1 magnitude |re| + |im| of a complex sample, with the beat
// qualifiers delayed alongside so they stay aligned with the magnitude.
module cplx_mag_l1 import spectrum_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     mag_valid,
  output logic                     mag_sop,
  output logic                     mag_eop,
  output logic        [DATA_W:0]   mag
);

  logic [DATA_W:0] re_ext;
  logic [DATA_W:0] im_ext;
  logic [DATA_W:0] abs_re;
  logic [DATA_W:0] abs_im;
  logic [DATA_W:0] mag_sum;

  // One extra bit keeps |most negative| exact instead of wrapping.
  always_comb begin
    re_ext  = {in_real[DATA_W-1], in_real};
    im_ext  = {in_imag[DATA_W-1], in_imag};
    abs_re  = re_ext[DATA_W] ? -re_ext : re_ext;
    abs_im  = im_ext[DATA_W] ? -im_ext : im_ext;
    mag_sum = abs_re + abs_im;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mag_valid <= 1'b0;
      mag_sop   <= 1'b0;
      mag_eop   <= 1'b0;
      mag       <= '0;
    end else begin
      mag_valid <= in_valid;
      mag_sop   <= in_sop;
      mag_eop   <= in_eop;
      mag       <= mag_sum;
    end
  end

endmodule

// File: rtl/fft_band_accumulator.sv
// Sums L1 magnitudes of the lower-half FFT bins into linear bands, converts
// each band to a saturated display level and applies peak-hold with decay.
module fft_band_accumulator import spectrum_pkg::*; #(
  parameter int unsigned FFT_LEN     = DefFftLen,
  parameter int unsigned NUM_BANDS   = DefNumBands,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned LEVEL_W     = DefLevelW,
  parameter int unsigned LEVEL_SHIFT = DefLevelShift,
  parameter int unsigned DECAY       = DefDecay
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         source_valid,
  input  logic                         source_sop,
  input  logic                         source_eop,
  input  logic signed [DATA_W-1:0]     source_real,
  input  logic signed [DATA_W-1:0]     source_imag,
  input  logic [$clog2(NUM_BANDS)-1:0] rd_addr,
  output logic [LEVEL_W-1:0]           rd_level,
  output logic                         frame_done,
  output logic                         frame_err
);

  localparam int unsigned HALF_LEN      = FFT_LEN / 2;
  localparam int unsigned BINS_PER_BAND = FFT_LEN / (2 * NUM_BANDS);
  localparam int unsigned SUM_W         = DATA_W + 1 + $clog2(BINS_PER_BAND);
  localparam int unsigned IDX_W         = $clog2(FFT_LEN) + 1;
  localparam int unsigned BAND_W        = $clog2(NUM_BANDS);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [LEVEL_W-1:0] DECAY_L   = LEVEL_W'(DECAY);

  logic            m_valid;
  logic            m_sop;
  logic            m_eop;
  logic [DATA_W:0] m_mag;

  cplx_mag_l1 #(
    .DATA_W (DATA_W)
  ) u_mag (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (source_valid),
    .in_sop    (source_sop),
    .in_eop    (source_eop),
    .in_real   (source_real),
    .in_imag   (source_imag),
    .mag_valid (m_valid),
    .mag_sop   (m_sop),
    .mag_eop   (m_eop),
    .mag       (m_mag)
  );

  band_state_e        state_q;
  logic [IDX_W-1:0]   bin_idx_q;
  logic [SUM_W-1:0]   acc_q;
  logic [LEVEL_W-1:0] pending_q [NUM_BANDS];
  logic [LEVEL_W-1:0] level_q   [NUM_BANDS];

  logic               beat_live;
  logic [IDX_W-1:0]   beat_idx;
  logic [IDX_W-1:0]   bin_in_band;
  logic [BAND_W-1:0]  band_sel;
  logic               band_first;
  logic               band_last;
  logic [SUM_W-1:0]   acc_next;
  logic [SUM_W-1:0]   acc_shift;
  logic [LEVEL_W-1:0] band_level;
  logic [LEVEL_W-1:0] decayed;
  logic [LEVEL_W-1:0] commit_level [NUM_BANDS];

  // A sop beat is taken in any state, which also restarts a partial frame.
  always_comb begin
    beat_live = m_valid && (m_sop || state_q == StAccum || state_q == StSkip);
    if (m_sop) begin
      beat_idx = '0;
    end else if (bin_idx_q == IDX_W'(FFT_LEN)) begin
      beat_idx = bin_idx_q;
    end else begin
      beat_idx = bin_idx_q + IDX_W'(1);
    end
    bin_in_band = beat_idx % IDX_W'(BINS_PER_BAND);
    band_sel    = BAND_W'(beat_idx / IDX_W'(BINS_PER_BAND));
    band_first  = (bin_in_band == '0);
    band_last   = (bin_in_band == IDX_W'(BINS_PER_BAND - 1));
    acc_next    = band_first ? SUM_W'(m_mag) : acc_q + SUM_W'(m_mag);
    acc_shift   = acc_next >> LEVEL_SHIFT;
    band_level  = (acc_shift > SUM_W'(LEVEL_MAX)) ? LEVEL_MAX : LEVEL_W'(acc_shift);
  end

  // Peak hold: a new band level wins only if it beats the decayed old level.
  always_comb begin
    decayed = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      decayed = (level_q[b] > DECAY_L) ? level_q[b] - DECAY_L : '0;
      commit_level[b] = (pending_q[b] > decayed) ? pending_q[b] : decayed;
    end
  end

  // Levels are written on the edge entering StCommit, so they are already
  // visible to reads issued during the frame_done cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      bin_idx_q  <= '0;
      acc_q      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rd_level   <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        pending_q[b] <= '0;
        level_q[b]   <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rd_level   <= level_q[rd_addr];
      if (beat_live) begin
        bin_idx_q <= beat_idx;
        if (m_sop && m_eop) begin
          frame_err <= 1'b1;
          state_q   <= StIdle;
        end else if (m_eop) begin
          if (beat_idx == IDX_W'(FFT_LEN - 1)) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
              level_q[b] <= commit_level[b];
            end
            frame_done <= 1'b1;
            state_q    <= StCommit;
          end else begin
            frame_err <= 1'b1;
            state_q   <= StIdle;
          end
        end else if (beat_idx == IDX_W'(FFT_LEN)) begin
          frame_err <= 1'b1;
          state_q   <= StIdle;
        end else if (beat_idx < IDX_W'(HALF_LEN)) begin
          acc_q <= acc_next;
          if (band_last) begin
            pending_q[band_sel] <= band_level;
          end
          state_q <= (beat_idx == IDX_W'(HALF_LEN - 1)) ? StSkip : StAccum;
        end else begin
          state_q <= StSkip;
        end
      end else if (state_q == StCommit) begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: doc/fft_band_accumulator.md
Name: fft_band_accumulator

Overview:
- Downstream consumer of one FFT channel (left or right); instantiated once per channel.
- Takes the streamed complex bins (real, imag, sop, eop, valid), computes an L1 magnitude per bin, and sums the lower-half bins into NUM_BANDS linear bands.
- Scales and saturates each band sum to a display level, then applies peak-hold with linear decay.
- Exposes the band levels to the visualizer through a registered read port, plus a per-frame done pulse.

Parameters:
- FFT_LEN, 256, bins per FFT frame; power of two, >= 2*NUM_BANDS.
- NUM_BANDS, 16, output bands; power of two.
- DATA_W, 16, width of signed source_real/source_imag.
- LEVEL_W, 8, width of the band level.
- LEVEL_SHIFT, 11, right shift applied to the band sum before saturation.
- DECAY, 1, peak-hold decrement per good frame.

Ports:
- clock  in  1  single block clock; the FFT source clock domain.
- reset  in  1  synchronous, active-high; clears all state.
- source_valid  in  1  bin beat qualifier.
- source_sop  in  1  first bin of frame; meaningful only with valid.
- source_eop  in  1  last bin of frame; meaningful only with valid.
- source_real  in  DATA_W  signed bin real part.
- source_imag  in  DATA_W  signed bin imaginary part.
- rd_addr  in  log2(NUM_BANDS)  band index to read.
- rd_level  out  LEVEL_W  level of band rd_addr; 1-cycle registered latency.
- frame_done  out  1  one-cycle pulse when levels have been updated.
- frame_err  out  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- Reset: all outputs 0; level registers 0; accumulators 0; FSM in IDLE.
- Derived constants:
  - BINS_PER_BAND = FFT_LEN/(2*NUM_BANDS).
  - SUM_W = DATA_W + 1 + log2(BINS_PER_BAND).
- Stage 1, magnitude (registered, 1 cycle):
  - mag = |re| + |im|, unsigned DATA_W+1 bits.
  - |-32768| = 32768 exactly; no wrap.
  - valid, sop and eop are delayed alongside mag.
- Stage 2, FSM, operating on stage-1 outputs:
  - IDLE: beat with sop -> ACCUM with bin_idx=0; current accumulator loaded with mag. Beats without sop are ignored.
  - ACCUM: each beat increments bin_idx and adds mag to the band accumulator.
    - When bin_idx%BINS_PER_BAND == BINS_PER_BAND-1, the band's level is written to the pending array and the accumulator reloads on the next beat.
    - After bin FFT_LEN/2-1 -> SKIP.
  - SKIP: upper-half beats are counted but not accumulated.
    - eop at bin_idx == FFT_LEN-1 -> COMMIT.
  - COMMIT (1 cycle):
    - For every b: level[b] = max(pending[b], sat0(level[b]-DECAY)).
    - frame_done=1; next state IDLE.
- Level computation: pending = min(sum >> LEVEL_SHIFT, 2^LEVEL_W-1).
- Latency: eop sampled at input cycle T -> frame_done high in cycle T+2. New levels are visible on rd_level one cycle after rd_addr is presented from T+2 onward.
- Error handling:
  - eop at any bin_idx != FFT_LEN-1, in ACCUM or SKIP, is an error.
  - sop and eop on the same beat is an error.
  - On error: frame_err pulses at T+2, pending is discarded, levels are unchanged, FSM returns to IDLE.
- sop while in ACCUM/SKIP:
  - The partial frame is discarded silently; no frame_err.
  - The FSM restarts at bin 0 with this beat.
- More than FFT_LEN beats without eop: bin_idx saturates; the beat at FFT_LEN is an error (frame_err), then IDLE.
- Gaps in valid are allowed anywhere; state holds.
- A sop beat arriving in the COMMIT cycle is accepted: the FSM goes to ACCUM and the commit still completes.
- rd_addr reads are independent of the FSM. A read in the COMMIT edge cycle returns the old value; the following cycle returns the new value.
- Reset mid-frame: everything clears, including levels; no frame_done or frame_err is generated.

Decomposition:
- Shared package spectrum_pkg holds: FFT_LEN, NUM_BANDS, DATA_W, LEVEL_W defaults; state enum {IDLE, ACCUM, SKIP, COMMIT}; clog2-derived widths.
- Sub-module cplx_mag_l1: the registered abs+add stage with valid/sop/eop delay. It is reused by the visualizer's peak detector.

Test Plan:
- Gain check: one frame, all 256 bins re=1024, im=0, valid continuous. Each band sum = 8192 -> every band level = 4; frame_done 2 cycles after eop; frame_err=0.
- Extreme values: only bin 8 has re=-32768, im=32767; other bins are 0. band1 = 65535>>11 = 31; all other bands 0; no overflow at -32768.
- Saturation: bins 0..7 have re=im=32767. band0 sum 524272>>11 = 255 -> 255. Next frame all zeros -> band0 = 254, band1 stays 0 (decay floor).
- Short frame: eop at bin 100 -> frame_err pulse, no frame_done, levels unchanged from the prior frame. The following good frame commits normally.
- Mid-frame restart: sop at bin 50, then a full 256-bin frame of re=1024. Levels = 4, a single frame_done, no frame_err.
- Valid gaps and reset: random 0–3 cycle valid gaps give results identical to the gap-free run. Reset asserted at bin 200 -> all levels read 0, no frame_done.
